// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: fixed-priority preemptive arbitration of clip
// requests onto a shared audio ROM and codec write port at sample rate.
module sfx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int ADDR_W     = 14,
  parameter int ROM_W      = 8,
  parameter int GAIN       = 1000,
  parameter int SAMPLE_DIV = 1134,
  parameter logic [NUM_REQ*ADDR_W-1:0] CLIP_BASE =
    {14'd12288, 14'd8192, 14'd4096, 14'd0},
  parameter logic [NUM_REQ*ADDR_W-1:0] CLIP_LEN = {4{14'd4096}}
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [ROM_W-1:0]   rom_q,
  input  logic               write_ready,
  output logic               write,
  output logic [23:0]        sample,
  output logic               busy,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_REQ-1:0] done,
  output logic               overrun
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic signed [31:0] GAIN_S = 32'(GAIN);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    PUSH
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] pending;
  logic [ADDR_W-1:0]  offset;

  logic               tick;
  logic               any;
  logic [ID_W-1:0]    win;
  logic               retire;
  logic [ADDR_W-1:0]  cur_len;
  logic               pbusy;
  logic [ADDR_W-1:0]  poff;
  logic [NUM_REQ-1:0] pdone;
  logic               take;
  logic [ID_W-1:0]    nid;
  logic [ADDR_W-1:0]  noff;
  logic               nbusy;
  logic [ADDR_W-1:0]  naddr;
  logic [NUM_REQ-1:0] clr;
  logic signed [31:0] prod;

  assign tick = cnt == CNT_W'(SAMPLE_DIV - 1);
  assign any  = |pending;

  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) win = ID_W'(i);
    end
  end

  // A tick landing in PUSH retires the held sample as if accepted.
  always_comb begin
    retire  = (state == PUSH) && (write_ready || tick);
    cur_len = CLIP_LEN[active_id*ADDR_W +: ADDR_W];
    pbusy   = busy;
    poff    = offset;
    pdone   = '0;
    if (retire && busy) begin
      if (offset == cur_len - ADDR_W'(1)) begin
        pbusy            = 1'b0;
        pdone[active_id] = 1'b1;
      end else begin
        poff = offset + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    take  = any && (!pbusy || win <= active_id);
    nid   = take ? win : active_id;
    noff  = take ? '0 : poff;
    nbusy = pbusy || take;
    naddr = CLIP_BASE[nid*ADDR_W +: ADDR_W] + noff;
    clr   = '0;
    if (tick && take) clr[win] = 1'b1;
  end

  assign prod =
    $signed({{(32-ROM_W){rom_q[ROM_W-1]}}, rom_q}) * GAIN_S;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      pending   <= '0;
      state     <= IDLE;
      rom_addr  <= '0;
      sample    <= '0;
      write     <= 1'b0;
      busy      <= 1'b0;
      active_id <= '0;
      done      <= '0;
      overrun   <= 1'b0;
      offset    <= '0;
    end else begin
      cnt     <= tick ? '0 : cnt + CNT_W'(1);
      pending <= (pending & ~clr) | req;
      done    <= pdone;
      if (retire) begin
        write  <= 1'b0;
        busy   <= pbusy;
        offset <= poff;
        if (!write_ready) overrun <= 1'b1;
      end
      unique case (state)
        IDLE, PUSH: begin
          if (tick) begin
            active_id <= nid;
            offset    <= noff;
            busy      <= nbusy;
            if (nbusy) begin
              rom_addr <= naddr;
              state    <= ADDR;
            end else begin
              sample <= '0;
              write  <= 1'b1;
              state  <= PUSH;
            end
          end else if (retire) begin
            state <= IDLE;
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          sample <= prod[23:0];
          write  <= 1'b1;
          state  <= PUSH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Random-stimulus bench for sfx_scheduler against a tick-level
// behavioural model of the clip scheduler.
module tb_sfx_scheduler;

  localparam int DIV  = 8;
  localparam int GAIN = 1000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [13:0] rom_addr;
  logic [7:0]  rom_q = '0;
  logic        write_ready;
  logic        write;
  logic [23:0] sample;
  logic        busy;
  logic [1:0]  active_id;
  logic [3:0]  done;
  logic        overrun;

  sfx_scheduler #(
    .SAMPLE_DIV(DIV),
    .CLIP_LEN({14'd6, 14'd3, 14'd9, 14'd4})
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req(req),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .write_ready(write_ready),
    .write(write),
    .sample(sample),
    .busy(busy),
    .active_id(active_id),
    .done(done),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rom_fn(input logic [13:0] a);
    logic [31:0] t;
    if (a == 14'd8192) return 8'hFB;
    t = 32'(a) * 37 + 32'(a >> 5);
    return t[7:0];
  endfunction

  always @(posedge clock) rom_q <= rom_fn(rom_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  int base [4] = '{0, 4096, 8192, 12288};
  int len  [4] = '{4, 9, 3, 6};

  int          m_e;
  bit [3:0]    m_pend;
  bit          m_busy;
  int          m_id;
  int          m_off;
  int          m_step;
  bit          m_write;
  logic [23:0] m_sample;
  logic [13:0] m_addr;
  bit [3:0]    m_done;
  bit          m_ovr;

  task automatic model_reset();
    m_e = 0; m_pend = '0; m_busy = 0; m_id = 0; m_off = 0;
    m_step = 0; m_write = 0; m_sample = '0; m_addr = '0;
    m_done = '0; m_ovr = 0;
  endtask

  function automatic logic [23:0] scaled(input logic [7:0] b);
    int sb;
    logic [31:0] pv;
    sb = int'($signed(b));
    pv = 32'(sb * GAIN);
    return pv[23:0];
  endfunction

  // One clock edge of the model, using the inputs held before that edge.
  task automatic model_edge(input bit [3:0] rq, input bit rdy);
    bit tk;
    int win;
    bit [3:0] clr;
    tk = (m_e % DIV) == DIV - 1;
    m_e++;
    m_done = '0;
    clr = '0;
    if (m_write && (rdy || tk)) begin
      if (!rdy) m_ovr = 1;
      m_write = 0;
      if (m_busy) begin
        if (m_off == len[m_id] - 1) begin
          m_busy = 0;
          m_done[m_id] = 1;
        end else begin
          m_off++;
        end
      end
    end
    if (m_step == 2) begin
      m_sample = scaled(rom_fn(m_addr));
      m_write = 1;
      m_step = 0;
    end else if (m_step == 1) begin
      m_step = 2;
    end
    if (tk) begin
      win = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i]) win = i;
      if (win >= 0 && (!m_busy || win <= m_id)) begin
        m_id = win; m_off = 0; m_busy = 1; clr[win] = 1;
      end
      if (m_busy) begin
        m_addr = 14'(base[m_id] + m_off);
        m_step = 1;
      end else begin
        m_sample = '0;
        m_write = 1;
      end
    end
    m_pend = (m_pend & ~clr) | rq;
  endtask

  task automatic check_all();
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("write", 32'(write), 32'(m_write));
    chk("sample", 32'(sample), 32'(m_sample));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("active_id", 32'(active_id), 32'(m_id));
    chk("done", 32'(done), 32'(m_done));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // rq_den: 1-in-N chance per bit of a request (0 = none);
  // nr_den: 1-in-N chance of write_ready high (0 = always ready).
  task automatic step(input int rq_den, input int nr_den);
    @(posedge clock);
    #1;
    model_edge(req, write_ready);
    check_all();
    for (int i = 0; i < 4; i++)
      req[i] = (rq_den != 0) && ($urandom_range(rq_den - 1) == 0);
    if (nr_den == 0) write_ready = 1'b1;
    else write_ready = ($urandom_range(nr_den - 1) != 0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    req = '0;
    write_ready = 1'b1;
    model_reset();
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0;
    write_ready = 1'b1;
    release_reset();

    repeat (30) step(0, 0);

    req = 4'b0100;
    step(0, 0);
    repeat (50) step(0, 0);

    req = 4'b1010;
    step(0, 0);
    repeat (150) step(0, 0);

    req = 4'b0100;
    step(0, 0);
    repeat (20) step(0, 0);
    req = 4'b0001;
    step(0, 0);
    repeat (60) step(0, 0);

    repeat (2000) step(60, 0);

    req = 4'b0010;
    step(0, 0);
    repeat (12) step(0, 0);
    repeat (30) step(0, 1);
    repeat (40) step(0, 0);

    repeat (2000) step(60, 6);

    req = 4'b0010;
    step(0, 0);
    repeat (20) step(0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    release_reset();
    repeat (60) step(0, 0);
    repeat (1000) step(50, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
- Shares the single audio ROM and the codec write port between NUM_REQ sound-effect requesters (bomb placed, explosion, player death, pickup).
- Fixed-priority arbitration with preemption; lower request index wins.
- Walks the selected clip's ROM address range at the audio sample rate, scales each sample and drives the codec left/right write handshake.
- Feeds silence when no clip is active.

Parameters:
- NUM_REQ, 4, number of requesters.
- ID_W, 2, width of active_id; equals clog2(NUM_REQ).
- ADDR_W, 14, ROM address width.
- ROM_W, 8, signed ROM sample width.
- GAIN, 1000, signed multiplier applied to each ROM sample.
- SAMPLE_DIV, 1134, clock cycles per sample tick (50 MHz / 44.1 kHz); must be >= 4.
- CLIP_BASE, {14'd12288,14'd8192,14'd4096,14'd0}, packed start address; clip i occupies bits [i*ADDR_W +: ADDR_W].
- CLIP_LEN, {4{14'd4096}}, packed clip lengths in samples, same packing; each entry >= 1.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester play request; a 1-cycle pulse or a level (rising edges not required); sampled every cycle.
- rom_addr  out  ADDR_W  ROM address; the ROM returns rom_q one clock later.
- rom_q  in  ROM_W  signed ROM data.
- write_ready  in  1  codec can accept a sample.
- write  out  1  sample valid toward codec.
- sample  out  24  signed sample, drives both writedata_left and writedata_right.
- busy  out  1  a clip is playing.
- active_id  out  ID_W  index of the playing clip; valid while busy.
- done  out  NUM_REQ  1-cycle pulse when clip i plays its last sample.
- overrun  out  1  sticky; a sample was dropped; cleared only by reset.

Behaviour:
- Reset (asynchronous, reset_n=0): tick counter=0, pending=0, state=IDLE, rom_addr=0, sample=0, write=0, busy=0, active_id=0, done=0, overrun=0, offset=0.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps; tick=1 on the cycle count==SAMPLE_DIV-1. The first tick after reset is at cycle SAMPLE_DIV-1.
- Pending: pending[i] is set on any cycle with req[i]=1 and cleared when clip i is selected. A set and a clear in the same cycle resolve to set.
- State machine, on each tick:
  - Priority: the winner is the lowest-index bit of pending.
  - Start: if !busy and pending!=0, load the winner into active_id, set offset=0 and busy=1, clear its pending bit, go to ADDR.
  - Preempt: if busy and the winner's index < active_id, switch to the winner in the same way. The preempted clip is abandoned, with no done pulse and no re-queue.
  - Retrigger: if busy and pending[active_id] is set, restart the active clip at offset 0 and clear that bit.
  - Continue: otherwise, if busy, go to ADDR with the current offset.
  - Silence: if !busy and pending=0, set sample=0, write=1, go to PUSH.
- ADDR (1 cycle): rom_addr = base[active_id] + offset, modulo 2^ADDR_W. Go to DATA.
- DATA (1 cycle): rom_q is valid. sample = sign-extended rom_q * GAIN, truncated to 24 bits; the product is computed in at least 24 bits with no saturation. write=1. Go to PUSH.
- PUSH:
  - On a cycle with write && write_ready: write=0.
  - If busy and offset==len[active_id]-1: busy=0 and done[active_id] pulses for 1 cycle. Otherwise offset+1.
  - Go to IDLE, where the FSM waits for the next tick.
- Overrun: if a tick arrives while still in PUSH, the held sample is dropped. overrun=1, and the offset advance/done logic runs as if accepted. The tick is then processed normally in that same cycle.
- Latency: tick to write=1 is 2 clocks for ROM samples and 0 clocks for silence (write rises the cycle after tick).
- sample holds its value between updates; write never stays high across a tick.
- Requests arriving in ADDR/DATA/PUSH only set pending. They take effect at the next tick.

Test Plan:
1. SAMPLE_DIV=8, CLIP_LEN[2]=3, write_ready=1; pulse req[2] once. Expect rom_addr 8192, 8193, 8194 on three consecutive ticks; busy high for three samples; done[2] pulse after the third accept; then writes of sample=0. With rom_q=-5, expect sample=-5000 (24'hFFEC78).
2. req[3] and req[1] pulsed in the same cycle. Expect clip 1 (base 4096) to play fully, then clip 3 (base 12288); done[1] before done[3].
3. Clip 2 playing at offset 5; pulse req[0]. Expect next tick rom_addr=0, active_id=0, no done[2]; clip 2 is not resumed afterwards.
4. Clip 1 playing at offset 7; pulse req[1]. Expect next tick rom_addr=4096 (restart); exactly one done[1] when the clip ends.
5. Hold write_ready=0 across a tick while playing. Expect overrun=1 to stay set; offset advances by 1 per tick; write drops at the tick boundary and re-asserts 2 cycles later.
6. Assert reset_n=0 mid-clip, asynchronously between clock edges. Expect all outputs to clear immediately. After release, expect silence writes only until a new req.
